// File: rtl/scan_sequencer_if.sv
// Command handshake between the host-side source and scan_sequencer.
// master drives in_valid/in_word/clr_req; slave returns in_ready.
interface scan_sequencer_if #(
  parameter int WORD_W = 8
);
  logic              in_valid;
  logic [WORD_W-1:0] in_word;
  logic              clr_req;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_word,
    output clr_req,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_word,
    input  clr_req,
    output in_ready
  );
endinterface

// File: rtl/scan_sequencer.sv
// Serialises a WORD_W-bit instruction MSB-first and emits clear/shift/update/run strobes.
// Ports: clk, reset_n, cmd (slave handshake), ser_data, clear, shift, update, run, busy, done.
module scan_sequencer #(
  parameter int WORD_W     = 8,
  parameter int RUN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  scan_sequencer_if.slave   cmd,
  output logic              ser_data,
  output logic              clear,
  output logic              shift,
  output logic              update,
  output logic              run,
  output logic              busy,
  output logic              done
);

  // One counter serves both SHIFT and RUN, so size it for the larger.
  localparam int NMAX = (WORD_W > RUN_CYCLES) ? WORD_W : RUN_CYCLES;
  localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  localparam logic [CW-1:0] SHIFT_LAST = CW'(WORD_W - 1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_UPDATE,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;

  logic rdy_q, clr_q, shf_q, upd_q, run_q, done_q, ser_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    unique case (state_q)
      S_IDLE: begin
        // clear wins over a pending word; the word stays pending
        if (cmd.clr_req) begin
          state_d = S_CLEAR;
        end else if (cmd.in_valid) begin
          word_d  = cmd.in_word;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_CLEAR: state_d = S_DONE;
      S_SHIFT: begin
        // word shifts left so the MSB is always the next bit out
        word_d = {word_q[WORD_W-2:0], 1'b0};
        if (cnt_q == SHIFT_LAST) begin
          state_d = S_UPDATE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_UPDATE: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == RUN_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are flops loaded from the next state, so they are
  // glitch-free and aligned with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      rdy_q   <= 1'b1;
      clr_q   <= 1'b0;
      shf_q   <= 1'b0;
      upd_q   <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      rdy_q   <= (state_d == S_IDLE);
      clr_q   <= (state_d == S_CLEAR);
      shf_q   <= (state_d == S_SHIFT);
      upd_q   <= (state_d == S_UPDATE);
      run_q   <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
      ser_q   <= (state_d == S_SHIFT) & word_d[WORD_W-1];
    end
  end

  assign cmd.in_ready = rdy_q;
  assign busy         = ~rdy_q;
  assign clear        = clr_q;
  assign shift        = shf_q;
  assign update       = upd_q;
  assign run          = run_q;
  assign done         = done_q;
  assign ser_data     = ser_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: RUN_CYCLES=1 and RUN_CYCLES=3 instances, same stimulus.
// A queue-based model expands each accepted request into its expected cycle sequence.
module tb_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  scan_sequencer_if #(.WORD_W(8)) ifa ();
  scan_sequencer_if #(.WORD_W(8)) ifb ();

  logic ser_a, clr_a, shf_a, upd_a, run_a, busy_a, done_a;
  logic ser_b, clr_b, shf_b, upd_b, run_b, busy_b, done_b;

  scan_sequencer #(.WORD_W(8), .RUN_CYCLES(1)) u_a (
    .clk      (clk),
    .reset_n  (rst_n),
    .cmd      (ifa),
    .ser_data (ser_a),
    .clear    (clr_a),
    .shift    (shf_a),
    .update   (upd_a),
    .run      (run_a),
    .busy     (busy_a),
    .done     (done_a)
  );

  scan_sequencer #(.WORD_W(8), .RUN_CYCLES(3)) u_b (
    .clk      (clk),
    .reset_n  (rst_n),
    .cmd      (ifb),
    .ser_data (ser_b),
    .clear    (clr_b),
    .shift    (shf_b),
    .update   (upd_b),
    .run      (run_b),
    .busy     (busy_b),
    .done     (done_b)
  );

  // {in_ready, busy, clear, shift, update, run, done, ser_data}
  typedef logic [7:0] vec_t;
  localparam vec_t V_IDLE  = 8'b1000_0000;
  localparam vec_t V_CLEAR = 8'b0110_0000;
  localparam vec_t V_SHIFT = 8'b0101_0000;
  localparam vec_t V_UPD   = 8'b0100_1000;
  localparam vec_t V_RUN   = 8'b0100_0100;
  localparam vec_t V_DONE  = 8'b0100_0010;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  vec_t qa[$];
  vec_t qb[$];
  bit   idle_a, idle_b;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic vec_t obs_a();
    return {ifa.in_ready, busy_a, clr_a, shf_a, upd_a, run_a, done_a, ser_a};
  endfunction

  function automatic vec_t obs_b();
    return {ifb.in_ready, busy_b, clr_b, shf_b, upd_b, run_b, done_b, ser_b};
  endfunction

  // Expand one accepted request into the cycles that follow it.
  task automatic push_seq(input int d, input logic c, input logic [7:0] w,
                          input int runs);
    vec_t s[$];
    if (c) begin
      s.push_back(V_CLEAR);
    end else begin
      for (int k = 7; k >= 0; k--) s.push_back(V_SHIFT | vec_t'(w[k]));
      s.push_back(V_UPD);
      for (int r = 0; r < runs; r++) s.push_back(V_RUN);
    end
    s.push_back(V_DONE);
    foreach (s[i]) begin
      if (d == 0) qa.push_back(s[i]);
      else        qb.push_back(s[i]);
    end
  endtask

  task automatic check_step();
    vec_t ea, eb;
    ea = V_IDLE;
    eb = V_IDLE;
    idle_a = (qa.size() == 0);
    idle_b = (qb.size() == 0);
    if (!idle_a) ea = qa.pop_front();
    if (!idle_b) eb = qb.pop_front();
    chk("dut_run1", obs_a(), ea);
    chk("dut_run3", obs_b(), eb);
    chk("onehot_run1", $countones({clr_a, shf_a, upd_a, run_a}) <= 1, 1);
    chk("onehot_run3", $countones({clr_b, shf_b, upd_b, run_b}) <= 1, 1);
  endtask

  task automatic cycle(input logic v, input logic c, input logic [7:0] w);
    @(negedge clk);
    cyc++;
    check_step();
    ifa.in_valid = v;
    ifa.clr_req  = c;
    ifa.in_word  = w;
    ifb.in_valid = v;
    ifb.clr_req  = c;
    ifb.in_word  = w;
    if (rst_n) begin
      if (idle_a && (c || v)) push_seq(0, c, w, 1);
      if (idle_b && (c || v)) push_seq(1, c, w, 3);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom));
  endtask

  // Reset asserted between edges; outputs must drop without a clock.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_run1", obs_a(), V_IDLE);
    chk("async_rst_run3", obs_b(), V_IDLE);
    qa.delete();
    qb.delete();
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    ifa.in_valid = 1'b1;
    ifa.clr_req  = 1'b1;
    ifa.in_word  = 8'hFF;
    ifb.in_valid = 1'b1;
    ifb.clr_req  = 1'b1;
    ifb.in_word  = 8'hFF;

    // requests held during reset must be ignored
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    drain(2);

    // single instruction
    cycle(1'b1, 1'b0, 8'b0110_0101);
    drain(16);

    // clear wins, word stays pending and is taken afterwards
    cycle(1'b1, 1'b1, 8'hC3);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'hC3);
    drain(16);

    // requests while busy are dropped
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'hFF);
    drain(16);

    // reset mid-shift abandons the word
    cycle(1'b1, 1'b0, 8'h3C);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00);
    async_reset();
    cycle(1'b1, 1'b0, 8'hA5);
    drain(16);

    // back-to-back with in_valid held
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, (i < 14) ? 8'h12 : 8'h34);
    drain(20);

    // random traffic, word changes every cycle
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0,
            8'($urandom));
    end
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
